// File: rtl/led_update_scheduler.sv
// -----------------------------------------------------------------------------
// led_update_scheduler
//
// Round-robin scheduler for the 4-card red/green LED decoder. It keeps a
// colour/blink shadow and an update-pending flag for each card. One card at a
// time is driven onto the decoder's shared card_select/red/green bus. The
// select and colour lines always change on the same edge, so the decoder
// never latches a colour into the wrong card.
//
// Parameters
//   HOLD_CYCLES  cycles the bus is held stable for each card update (>= 1)
//   BLINK_DIV    blink half-period in clk cycles (>= 2, 16-bit prescaler)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   cmd_valid    MCU command present
//   cmd_ready    command accepted on an edge where cmd_valid & cmd_ready
//   cmd_card     target card 0..3
//   cmd_color    requested colour {green,red}
//   cmd_blink    1 = blink the colour on/off, 0 = steady
//   card_select  decoder cardSelect
//   red, green   decoder colour lines
//   busy         high while a card update is being driven
//   pending      per-card update-pending flags
// -----------------------------------------------------------------------------
module led_update_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int BLINK_DIV   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_card,
  input  logic [1:0] cmd_color,
  input  logic       cmd_blink,
  output logic [1:0] card_select,
  output logic       red,
  output logic       green,
  output logic       busy,
  output logic [3:0] pending
);

  localparam int                CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [15:0]       PRESC_LAST = 16'(BLINK_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Colour actually sent to the decoder: a blinking card goes dark in the off phase.
  function automatic logic [1:0] eff_color(input logic [1:0] color, input logic blink,
                                           input logic phase);
    logic [1:0] res;
    if (blink && phase) begin
      res = 2'b00;
    end else begin
      res = color;
    end
    return res;
  endfunction

  // First pending card scanning last+1, last+2, ... (wrapping back to last itself).
  // Returns {found, index}. The loop runs from the farthest candidate down to
  // the nearest, so the nearest pending card overwrites any earlier match.
  function automatic logic [2:0] pick_next(input logic [3:0] pend, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (pend[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           cur_q, cur_d;
  logic [1:0]           last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]          presc_q, presc_d;
  logic                 phase_q, phase_d;
  logic [3:0][1:0]      color_q, color_d;
  logic [3:0]           blink_q, blink_d;
  logic [3:0]           pending_q, pending_d;
  logic [1:0]           sel_q, sel_d;
  logic                 red_q, red_d;
  logic                 green_q, green_d;
  logic                 busy_q, busy_d;

  logic                 wrap_s;
  logic                 ready_s;
  logic                 fire_s;
  logic [2:0]           pick_s;
  logic [1:0]           eff_s;
  logic [3:0]           pend_set_s;
  logic [3:0]           pend_clr_s;

  // Next-state logic: prescaler/phase, shadows, pending flags and the IDLE/DRIVE FSM.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    presc_d    = presc_q;
    phase_d    = phase_q;
    color_d    = color_q;
    blink_d    = blink_q;
    sel_d      = sel_q;
    red_d      = red_q;
    green_d    = green_q;
    pend_set_s = 4'b0000;
    pend_clr_s = 4'b0000;
    eff_s      = 2'b00;

    // The card currently on the bus cannot take a new command until its
    // update finishes; every other card is always writable.
    ready_s = ~((state_q == ST_DRIVE) && (cmd_card == cur_q));
    fire_s  = cmd_valid & ready_s;
    pick_s  = pick_next(pending_q, last_q);

    wrap_s = (presc_q == PRESC_LAST);
    if (wrap_s) begin
      presc_d    = 16'd0;
      phase_d    = ~phase_q;
      pend_set_s = blink_q;
    end else begin
      presc_d    = presc_q + 16'd1;
      phase_d    = phase_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_s[2]) begin
          // Colour is sampled here; later shadow writes wait for the next service.
          eff_s   = eff_color(color_q[pick_s[1:0]], blink_q[pick_s[1:0]], phase_q);
          cur_d   = pick_s[1:0];
          sel_d   = pick_s[1:0];
          green_d = eff_s[1];
          red_d   = eff_s[0];
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          pend_clr_s[cur_q] = 1'b1;
          last_d            = cur_q;
          cnt_d             = {CNT_W{1'b0}};
          state_d           = ST_IDLE;
        end else begin
          cnt_d             = cnt_q + CNT_W'(1);
          state_d           = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fire_s) begin
      color_d[cmd_card]    = cmd_color;
      blink_d[cmd_card]    = cmd_blink;
      pend_set_s[cmd_card] = 1'b1;
    end else begin
      color_d = color_d;
    end

    // Set has priority over clear, so a card re-requested on its final
    // DRIVE cycle is served again.
    pending_d = (pending_q & ~pend_clr_s) | pend_set_s;
    busy_d    = (state_d == ST_DRIVE);
  end

  // State registers; reset forces every card pending so all LEDs get turned off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= 2'd0;
      last_q    <= 2'd3;
      cnt_q     <= {CNT_W{1'b0}};
      presc_q   <= 16'd0;
      phase_q   <= 1'b0;
      color_q   <= {4{2'b00}};
      blink_q   <= 4'b0000;
      pending_q <= 4'b1111;
      sel_q     <= 2'd0;
      red_q     <= 1'b0;
      green_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      color_q   <= color_d;
      blink_q   <= blink_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      red_q     <= red_d;
      green_q   <= green_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_ready   = ready_s;
  assign card_select = sel_q;
  assign red         = red_q;
  assign green       = green_q;
  assign busy        = busy_q;
  assign pending     = pending_q;

endmodule
